// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared SPI definitions used by the baud generator and the APB register block.
//   - SPI_RUN / SPI_WAIT / SPI_STOP : spi_mode encodings (2'b11 also means stop)
//   - DIV_W_DEF                     : default divisor / half-period counter width
//   - baud_state_e                  : IDLE / RUN state of the baud generator
//   - spi_divisor(sppr, spr)        : (sppr+1) * 2^(spr+1), range 2..2048
// -----------------------------------------------------------------------------
package spi_pkg;

  localparam int DIV_W_DEF = 12;

  localparam logic [1:0] SPI_RUN  = 2'b00;
  localparam logic [1:0] SPI_WAIT = 2'b01;
  localparam logic [1:0] SPI_STOP = 2'b10;

  typedef enum logic {
    BAUD_IDLE = 1'b0,
    BAUD_RUN  = 1'b1
  } baud_state_e;

  // Baud divisor from the SPPR/SPR register fields. The shift amount is
  // widened to 4 bits so that spr=7 gives a shift of 8 rather than wrapping.
  function automatic logic [DIV_W_DEF-1:0] spi_divisor(input logic [2:0] sppr,
                                                       input logic [2:0] spr);
    logic [DIV_W_DEF-1:0] mult;
    logic [3:0]           shamt;
    mult  = DIV_W_DEF'(sppr) + DIV_W_DEF'(1);
    shamt = {1'b0, spr} + 4'd1;
    return mult << shamt;
  endfunction

endpackage : spi_pkg

// File: rtl/spi_baud_generator_if.sv
// -----------------------------------------------------------------------------
// spi_baud_generator_if
// Bundles the register-field inputs and the SCLK / strobe outputs of the baud
// generator. PCLK and PRESET_i stay plain ports on the generator.
//   slave  modport : used by spi_baud_generator (consumes config, drives SCLK)
//   master modport : used by the surrounding SPI logic / testbench
// Signals:
//   ss_i, spi_mode_i[1:0], spiswai_i, cpol_i, cpha_i, sppr_i[2:0], spr_i[2:0]
//   sclk_o, miso_recieve_sclk_o, miso_recieve_sclk0_o,
//   mosi_send_sclk_o, mosi_send_sclk0_o, baudratedivisor_o[DIV_W-1:0]
// -----------------------------------------------------------------------------
interface spi_baud_generator_if
  import spi_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
);

  logic             ss_i;
  logic [1:0]       spi_mode_i;
  logic             spiswai_i;
  logic             cpol_i;
  logic             cpha_i;
  logic [2:0]       sppr_i;
  logic [2:0]       spr_i;

  logic             sclk_o;
  logic             miso_recieve_sclk_o;
  logic             miso_recieve_sclk0_o;
  logic             mosi_send_sclk_o;
  logic             mosi_send_sclk0_o;
  logic [DIV_W-1:0] baudratedivisor_o;

  modport slave (
    input  ss_i,
    input  spi_mode_i,
    input  spiswai_i,
    input  cpol_i,
    input  cpha_i,
    input  sppr_i,
    input  spr_i,
    output sclk_o,
    output miso_recieve_sclk_o,
    output miso_recieve_sclk0_o,
    output mosi_send_sclk_o,
    output mosi_send_sclk0_o,
    output baudratedivisor_o
  );

  modport master (
    output ss_i,
    output spi_mode_i,
    output spiswai_i,
    output cpol_i,
    output cpha_i,
    output sppr_i,
    output spr_i,
    input  sclk_o,
    input  miso_recieve_sclk_o,
    input  miso_recieve_sclk0_o,
    input  mosi_send_sclk_o,
    input  mosi_send_sclk0_o,
    input  baudratedivisor_o
  );

endinterface : spi_baud_generator_if

// File: rtl/spi_baud_div.sv
// -----------------------------------------------------------------------------
// spi_baud_div
// Combinational baud divisor computation from the SPPR/SPR register fields.
// Ports:
//   sppr_i[2:0]          in  : prescaler selection
//   spr_i[2:0]           in  : rate selection
//   divisor_o[DIV_W-1:0] out : (sppr+1) * 2^(spr+1)
//   half_o[DIV_W-1:0]    out : divisor / 2 (always >= 1)
//   half_m1_o[DIV_W-1:0] out : half - 1, the counter wrap threshold
// -----------------------------------------------------------------------------
module spi_baud_div
  import spi_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic [2:0]       sppr_i,
  input  logic [2:0]       spr_i,
  output logic [DIV_W-1:0] divisor_o,
  output logic [DIV_W-1:0] half_o,
  output logic [DIV_W-1:0] half_m1_o
);

  logic [DIV_W_DEF-1:0] div_full;

  assign div_full  = spi_divisor(sppr_i, spr_i);
  assign divisor_o = DIV_W'(div_full);
  assign half_o    = divisor_o >> 1;
  // half is never 0 (minimum divisor is 2), so this cannot underflow.
  assign half_m1_o = half_o - DIV_W'(1);

endmodule : spi_baud_div

// File: rtl/spi_baud_generator.sv
// -----------------------------------------------------------------------------
// spi_baud_generator
// Generates SCLK and the four edge strobes used by the SPI shifter.
// Ports:
//   PCLK      in : system clock, rising edge
//   PRESET_i  in : asynchronous active-low reset
//   bus       slave modport of spi_baud_generator_if (config in, SCLK/strobes
//             and divisor readback out)
// Behaviour summary:
//   - IDLE holds the counter at 0 and SCLK at cpol.
//   - RUN counts PCLK cycles; at count >= half-1 the counter wraps and SCLK
//     toggles, giving a period of exactly `divisor` PCLK cycles.
//   - Strobes mark the PCLK cycle whose closing edge toggles SCLK; the pair
//     used is selected by cpol^cpha (plain pair for 0, *0 pair for 1).
// Build option:
//   SPI_BAUD_WAIT_MODE_EN : when defined, wait mode with spiswai_i=1 stops
//   generation. When undefined, spiswai_i is ignored and wait acts as run.
// -----------------------------------------------------------------------------
module spi_baud_generator
  import spi_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input logic                 PCLK,
  input logic                 PRESET_i,
  spi_baud_generator_if.slave bus
);

  // ---------------------------------------------------------------------------
  // Divisor
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] divisor;
  logic [DIV_W-1:0] half;
  logic [DIV_W-1:0] half_m1;

  spi_baud_div #(
    .DIV_W (DIV_W)
  ) u_div (
    .sppr_i    (bus.sppr_i),
    .spr_i     (bus.spr_i),
    .divisor_o (divisor),
    .half_o    (half),
    .half_m1_o (half_m1)
  );

  assign bus.baudratedivisor_o = divisor;

  // ---------------------------------------------------------------------------
  // Enable decode
  // ---------------------------------------------------------------------------
  logic mode_ok;
  logic active;

`ifdef SPI_BAUD_WAIT_MODE_EN
  assign mode_ok = (bus.spi_mode_i == SPI_RUN) ||
                   ((bus.spi_mode_i == SPI_WAIT) && !bus.spiswai_i);
`else
  // Wait mode never halts the clock in this build; spiswai_i is kept on the
  // interface only so both builds share one port list.
  logic unused_spiswai;
  assign unused_spiswai = bus.spiswai_i;
  assign mode_ok = (bus.spi_mode_i == SPI_RUN) || (bus.spi_mode_i == SPI_WAIT);
`endif

  assign active = !bus.ss_i && mode_ok;

  // ---------------------------------------------------------------------------
  // State, counter and SCLK registers
  // ---------------------------------------------------------------------------
  baud_state_e      state_reg, state_next;
  logic [DIV_W-1:0] count_reg, count_next;
  logic             sclk_reg,  sclk_next;
  logic             wrap;

  // '>=' rather than '==' so that a smaller divisor loaded mid-run still
  // wraps on the next cycle instead of counting all the way round.
  assign wrap = (count_reg >= half_m1);

  always_ff @(posedge PCLK or negedge PRESET_i) begin
    if (!PRESET_i) begin
      state_reg <= BAUD_IDLE;
      count_reg <= '0;
      sclk_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      sclk_reg  <= sclk_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    sclk_next  = sclk_reg;
    unique case (state_reg)
      BAUD_IDLE: begin
        count_next = '0;
        sclk_next  = bus.cpol_i;
        if (active) begin
          state_next = BAUD_RUN;
        end
      end
      BAUD_RUN: begin
        if (!active) begin
          // Abandon the current period immediately; no partial completion.
          state_next = BAUD_IDLE;
          count_next = '0;
          sclk_next  = bus.cpol_i;
        end else if (wrap) begin
          count_next = '0;
          sclk_next  = ~sclk_reg;
        end else begin
          count_next = count_reg + DIV_W'(1);
        end
      end
      default: begin
        state_next = BAUD_IDLE;
        count_next = '0;
        sclk_next  = bus.cpol_i;
      end
    endcase
  end

  assign bus.sclk_o = sclk_reg;

  // ---------------------------------------------------------------------------
  // Strobe decode
  // Built only from the registered state plus the static register fields, so
  // the strobes do not depend on ss_i / spi_mode_i timing.
  // ---------------------------------------------------------------------------
  logic       edge_due;
  logic       leading_due;
  logic       sample_due;
  logic       shift_due;
  logic       pair_sel;
  logic [1:0] pair_en;
  logic [1:0] sample_vec;
  logic [1:0] shift_vec;

  assign edge_due    = (state_reg == BAUD_RUN) && wrap;
  // The pending toggle leaves the idle level when SCLK currently sits at cpol.
  assign leading_due = (sclk_reg == bus.cpol_i);
  // cpha=0 samples on leading edges, cpha=1 on trailing edges.
  assign sample_due  = edge_due &&  (leading_due ^ bus.cpha_i);
  assign shift_due   = edge_due && !(leading_due ^ bus.cpha_i);
  assign pair_sel    = bus.cpol_i ^ bus.cpha_i;

  // Index 0 is the plain pair (cpol^cpha=0), index 1 the *0 pair.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_pair
      assign pair_en[gi]    = (pair_sel == 1'(gi));
      assign sample_vec[gi] = sample_due && pair_en[gi];
      assign shift_vec[gi]  = shift_due  && pair_en[gi];
    end
  endgenerate

  assign bus.miso_recieve_sclk_o  = sample_vec[0];
  assign bus.miso_recieve_sclk0_o = sample_vec[1];
  assign bus.mosi_send_sclk_o     = shift_vec[0];
  assign bus.mosi_send_sclk0_o    = shift_vec[1];

endmodule : spi_baud_generator

// File: tb/tb_spi_baud_generator.sv
// -----------------------------------------------------------------------------
// tb_spi_baud_generator
// Directed phases followed by randomized transfers. The reference model tracks
// how many cycles the generator has been running and derives SCLK and the
// strobes from the divisor arithmetic: SCLK flips every `half` cycles, and a
// strobe accompanies the cycle closing each half period.
// -----------------------------------------------------------------------------
module tb_spi_baud_generator;
  import spi_pkg::*;

  logic pclk;
  logic preset_n;
  int   checks = 0;
  int   errors = 0;

  spi_baud_generator_if #(.DIV_W(12)) bus ();

  spi_baud_generator #(
    .DIV_W (12)
  ) dut (
    .PCLK     (pclk),
    .PRESET_i (preset_n),
    .bus      (bus.slave)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  bit m_run         = 1'b0;  // generator is in its running state this cycle
  int m_k           = 0;     // cycles since the running phase began
  bit m_base        = 1'b0;  // SCLK level at the start of the running phase
  bit m_idle_sclk   = 1'b0;  // SCLK level while not running
  bit m_rebase      = 1'b0;  // divisor shrank mid-run: restart phase at next edge
  bit m_rebase_sclk = 1'b0;  // SCLK level held just before that edge

  function automatic int divisor_f();
    return (int'(bus.sppr_i) + 1) * (2 ** (int'(bus.spr_i) + 1));
  endfunction

  function automatic int half_f();
    return divisor_f() / 2;
  endfunction

  function automatic bit active_f();
`ifdef SPI_BAUD_WAIT_MODE_EN
    return !bus.ss_i && ((bus.spi_mode_i == 2'b00) ||
                         (bus.spi_mode_i == 2'b01 && !bus.spiswai_i));
`else
    return !bus.ss_i && (bus.spi_mode_i <= 2'b01);
`endif
  endfunction

  function automatic bit exp_sclk();
    if (!m_run) return m_idle_sclk;
    return m_base ^ (((m_k / half_f()) % 2) != 0);
  endfunction

  // {miso_recieve_sclk, miso_recieve_sclk0, mosi_send_sclk, mosi_send_sclk0}
  function automatic logic [3:0] exp_strobes();
    bit lead;
    bit sample;
    if (!m_run) return 4'b0000;
    if (((m_k + 1) % half_f()) != 0) return 4'b0000;
    lead   = (exp_sclk() == bus.cpol_i);
    sample = bus.cpha_i ? !lead : lead;
    if ((bus.cpol_i ^ bus.cpha_i) == 1'b0) return {sample, 1'b0, !sample, 1'b0};
    return {1'b0, sample, 1'b0, !sample};
  endfunction

  // Advance the model across one rising PCLK edge, using the inputs present at it.
  task automatic model_edge();
    bit act;
    act = active_f();
    if (!m_run) begin
      m_idle_sclk = bus.cpol_i;
      if (act) begin
        m_run  = 1'b1;
        m_k    = 0;
        m_base = bus.cpol_i;
      end
    end else if (!act) begin
      m_run       = 1'b0;
      m_idle_sclk = bus.cpol_i;
      m_rebase    = 1'b0;
    end else if (m_rebase) begin
      m_base   = ~m_rebase_sclk;
      m_k      = 0;
      m_rebase = 1'b0;
    end else begin
      m_k++;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [3:0] s;
    s = exp_strobes();
    chk("sclk",                32'(bus.sclk_o),               32'(exp_sclk()));
    chk("miso_recieve_sclk",   32'(bus.miso_recieve_sclk_o),  32'(s[3]));
    chk("miso_recieve_sclk0",  32'(bus.miso_recieve_sclk0_o), 32'(s[2]));
    chk("mosi_send_sclk",      32'(bus.mosi_send_sclk_o),     32'(s[1]));
    chk("mosi_send_sclk0",     32'(bus.mosi_send_sclk0_o),    32'(s[0]));
    chk("baudratedivisor",     32'(bus.baudratedivisor_o),    32'(divisor_f()));
  endtask

  task automatic tick();
    @(posedge pclk);
    if (preset_n) model_edge();
    #2;
    check_outputs();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int n_sample;
  int n_shift;
  int run_len;

  initial begin
    bus.ss_i       = 1'b1;
    bus.spi_mode_i = SPI_RUN;
    bus.spiswai_i  = 1'b0;
    bus.cpol_i     = 1'b0;
    bus.cpha_i     = 1'b0;
    bus.sppr_i     = 3'd0;
    bus.spr_i      = 3'd0;
    preset_n       = 1'b0;

    // Reset values (divisor readback is valid during reset).
    #3;
    check_outputs();
    $display("reset: sclk=%0b divisor=%0d", bus.sclk_o, bus.baudratedivisor_o);
    #4 preset_n = 1'b1;

    // Fastest rate, mode 0.
    ticks(2);
    bus.ss_i = 1'b0;
    ticks(14);
    bus.ss_i = 1'b1;
    ticks(3);
    $display("phase fastest mode0 done: checks=%0d", checks);

    // Divisor 8: 64 running cycles must hold exactly 8 sample and 8 shift strobes.
    bus.sppr_i = 3'd1;
    bus.spr_i  = 3'd1;
    #1 chk("divisor8", 32'(bus.baudratedivisor_o), 32'd8);
    bus.ss_i = 1'b0;
    tick();
    n_sample = 0;
    n_shift  = 0;
    for (int i = 0; i < 64; i++) begin
      n_sample += int'(bus.miso_recieve_sclk_o);
      n_shift  += int'(bus.mosi_send_sclk_o);
      tick();
    end
    chk("div8_sample_count", 32'(n_sample), 32'd8);
    chk("div8_shift_count",  32'(n_shift),  32'd8);
    bus.ss_i = 1'b1;
    ticks(3);
    $display("phase divisor8 done: samples=%0d shifts=%0d", n_sample, n_shift);

    // cpol=1, cpha=0, divisor 4: idle high, *0 pair only.
    bus.cpol_i = 1'b1;
    bus.sppr_i = 3'd0;
    bus.spr_i  = 3'd1;
    tick();
    chk("cpol1_idle", 32'(bus.sclk_o), 32'd1);
    bus.ss_i = 1'b0;
    ticks(20);
    bus.ss_i = 1'b1;
    ticks(3);
    $display("phase cpol1 done: checks=%0d", checks);

    // Drop ss after 3 SCLK edges (divisor 4, edges close cycles 1, 3, 5).
    bus.cpol_i = 1'b0;
    tick();
    bus.ss_i = 1'b0;
    ticks(7);
    bus.ss_i = 1'b1;
    tick();
    chk("drop_ss_sclk", 32'(bus.sclk_o), 32'(bus.cpol_i));
    ticks(3);
    $display("phase drop ss done: sclk=%0b", bus.sclk_o);

    // Enter wait mode with stop-in-wait while running.
    bus.ss_i = 1'b0;
    ticks(6);
    bus.spi_mode_i = SPI_WAIT;
    bus.spiswai_i  = 1'b1;
    ticks(10);
    bus.spi_mode_i = SPI_STOP;
    ticks(4);
    bus.spi_mode_i = SPI_RUN;
    bus.spiswai_i  = 1'b0;
    ticks(5);
    bus.ss_i = 1'b1;
    ticks(3);
    $display("phase wait mode done: checks=%0d", checks);

    // Reset mid-period (divisor 8, SCLK high at running cycle 5).
    bus.sppr_i = 3'd1;
    bus.spr_i  = 3'd1;
    tick();
    bus.ss_i = 1'b0;
    ticks(6);
    #1 preset_n = 1'b0;
    m_run       = 1'b0;
    m_idle_sclk = 1'b0;
    m_rebase    = 1'b0;
    #1 check_outputs();
    #1 preset_n = 1'b1;
    ticks(20);
    bus.ss_i = 1'b1;
    ticks(3);
    $display("phase reset mid-transfer done: checks=%0d", checks);

    // Divisor 16 -> 2 while the counter sits at 6.
    bus.sppr_i = 3'd0;
    bus.spr_i  = 3'd3;
    tick();
    bus.ss_i = 1'b0;
    ticks(7);
    m_rebase_sclk = exp_sclk();
    bus.spr_i     = 3'd0;
    m_rebase      = 1'b1;
    #1 chk("divchg_wrap_strobe", 32'(bus.miso_recieve_sclk_o), 32'd1);
    ticks(10);
    bus.ss_i = 1'b1;
    ticks(3);
    $display("phase divisor change done: checks=%0d", checks);

    // Randomized transfers.
    for (int it = 0; it < 30; it++) begin
      bus.ss_i = 1'b1;
      ticks(2);
      bus.cpol_i     = 1'($urandom_range(1, 0));
      bus.cpha_i     = 1'($urandom_range(1, 0));
      bus.sppr_i     = 3'($urandom_range(3, 0));
      bus.spr_i      = 3'($urandom_range(3, 0));
      bus.spi_mode_i = 2'($urandom_range(3, 0));
      bus.spiswai_i  = 1'($urandom_range(1, 0));
      if ($urandom_range(1, 0) == 0) bus.spi_mode_i = SPI_RUN;
      tick();
      bus.ss_i = 1'b0;
      run_len  = int'($urandom_range(80, 5));
      for (int c = 0; c < run_len; c++) begin
        if ($urandom_range(15, 0) == 0) begin
          bus.spi_mode_i = 2'($urandom_range(3, 0));
          bus.spiswai_i  = 1'($urandom_range(1, 0));
        end
        tick();
      end
      $display("random %0d: cpol=%0b cpha=%0b div=%0d cycles=%0d",
               it, bus.cpol_i, bus.cpha_i, divisor_f(), run_len);
    end
    bus.ss_i = 1'b1;
    ticks(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_spi_baud_generator
